// File: rtl/program_loader.sv
// Program-memory loader: assembles a nibble-serial boot stream (LEN, data, CSUM) into
// sequential program-memory writes and holds the core in reset until a clean load completes.
module program_loader #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 1023
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic [3:0]        i_nib_in,
    input  logic              i_nib_valid,
    output logic              o_nib_ready,
    output logic [ADDR_W-1:0] o_pm_wr_addr,
    output logic [DATA_W-1:0] o_pm_wr_data,
    output logic              o_pm_wren,
    output logic              o_cpu_hold,
    output logic              o_busy,
    output logic              o_load_done,
    output logic [1:0]        o_error_code
);

    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_LEN_H = 4'd1;
    localparam logic [3:0] S_LEN_L = 4'd2;
    localparam logic [3:0] S_DAT_H = 4'd3;
    localparam logic [3:0] S_DAT_L = 4'd4;
    localparam logic [3:0] S_WRITE = 4'd5;
    localparam logic [3:0] S_CSM_H = 4'd6;
    localparam logic [3:0] S_CSM_L = 4'd7;
    localparam logic [3:0] S_DONE  = 4'd8;
    localparam logic [3:0] S_ERROR = 4'd9;

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W:0] CNT_FULL = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    logic [3:0]        r_state;
    logic              r_sync_reset;
    logic [3:0]        r_hi;
    logic [ADDR_W:0]   r_count;
    logic [7:0]        r_sum;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic [TW-1:0]     r_timer;
    logic              r_load_done;
    logic [1:0]        r_err;

    logic              w_xfer;
    logic [7:0]        w_byte;
    logic              w_idle_like;

    assign w_byte      = {r_hi, i_nib_in};
    assign w_idle_like = (r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERROR);
    assign o_nib_ready = (r_state == S_LEN_H) || (r_state == S_LEN_L) ||
                         (r_state == S_DAT_H) || (r_state == S_DAT_L) ||
                         (r_state == S_CSM_H) || (r_state == S_CSM_L);
    assign w_xfer      = i_nib_valid & o_nib_ready;

    // Write strobe is suppressed as soon as reset is seen, before the sync stage lands.
    assign o_pm_wren    = (r_state == S_WRITE) & ~i_reset & ~r_sync_reset;
    assign o_busy       = ~w_idle_like;
    assign o_cpu_hold   = (r_state != S_DONE);
    assign o_load_done  = r_load_done;
    assign o_error_code = r_err;
    assign o_pm_wr_addr = r_addr;
    assign o_pm_wr_data = r_data;

    always_ff @(posedge i_clk) begin
        r_sync_reset <= i_reset;
    end

    always_ff @(posedge i_clk) begin
        if (r_sync_reset) begin
            r_state     <= S_IDLE;
            r_hi        <= '0;
            r_count     <= '0;
            r_sum       <= '0;
            r_addr      <= '0;
            r_data      <= '0;
            r_timer     <= '0;
            r_load_done <= 1'b0;
            r_err       <= 2'b00;
        end else begin
            case (r_state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (i_start) begin
                        r_state     <= S_LEN_H;
                        r_sum       <= '0;
                        r_addr      <= '0;
                        r_timer     <= '0;
                        r_err       <= 2'b00;
                        r_load_done <= 1'b0;
                    end
                end
                S_LEN_H, S_DAT_H, S_CSM_H: begin
                    if (w_xfer) begin
                        r_hi    <= i_nib_in;
                        r_state <= r_state + 4'd1;
                    end
                end
                S_LEN_L: begin
                    if (w_xfer) begin
                        r_count <= (w_byte == 8'd0) ? CNT_FULL : (ADDR_W + 1)'(w_byte);
                        r_state <= S_DAT_H;
                    end
                end
                S_DAT_L: begin
                    if (w_xfer) begin
                        r_data  <= DATA_W'(w_byte);
                        r_sum   <= r_sum + w_byte;
                        r_state <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    r_addr  <= r_addr + 1'b1;
                    r_count <= r_count - 1'b1;
                    r_state <= (r_count == (ADDR_W + 1)'(1)) ? S_CSM_H : S_DAT_H;
                end
                S_CSM_L: begin
                    if (w_xfer) begin
                        if (w_byte == r_sum) begin
                            r_state     <= S_DONE;
                            r_load_done <= 1'b1;
                        end else begin
                            r_state <= S_ERROR;
                            r_err   <= 2'b01;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            // Timeout overrides any state change decided above.
            if (o_nib_ready) begin
                if (w_xfer) begin
                    r_timer <= '0;
                end else if (r_timer == TMO_LAST) begin
                    r_timer <= '0;
                    r_state <= S_ERROR;
                    r_err   <= 2'b10;
                end else begin
                    r_timer <= r_timer + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: a stream model predicts writes and load outcome,
// a negedge monitor checks every pm_wren pulse against the expected-write queue.
module tb_program_loader;

    localparam int ADDR_W  = 8;
    localparam int TIMEOUT = 1023;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [3:0]        nib_in;
    logic              nib_valid;
    logic              nib_ready;
    logic [ADDR_W-1:0] pm_wr_addr;
    logic [7:0]        pm_wr_data;
    logic              pm_wren;
    logic              cpu_hold;
    logic              busy;
    logic              load_done;
    logic [1:0]        error_code;

    always #5 clk = ~clk;

    program_loader #(.ADDR_W(ADDR_W), .DATA_W(8), .TIMEOUT(TIMEOUT)) dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_start      (start),
        .i_nib_in     (nib_in),
        .i_nib_valid  (nib_valid),
        .o_nib_ready  (nib_ready),
        .o_pm_wr_addr (pm_wr_addr),
        .o_pm_wr_data (pm_wr_data),
        .o_pm_wren    (pm_wren),
        .o_cpu_hold   (cpu_hold),
        .o_busy       (busy),
        .o_load_done  (load_done),
        .o_error_code (error_code)
    );

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;

    int         tests = 0;
    int         fails = 0;
    wr_t        exp_q[$];
    wr_t        mon_e;
    logic [7:0] obs_mem[256];
    logic [7:0] ref_mem[256];
    logic [7:0] img[256];
    int         img_n;
    logic       prev_wren = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every write strobe must match the next predicted write.
    always @(negedge clk) begin
        if (pm_wren === 1'b1) begin
            obs_mem[pm_wr_addr] = pm_wr_data;
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_write: addr %0h data %0h with empty queue", pm_wr_addr, pm_wr_data);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", 32'(pm_wr_addr), 32'(mon_e.addr));
                check("wr_data", 32'(pm_wr_data), 32'(mon_e.data));
            end
            check("wren_single_pulse", 32'(prev_wren), 32'd0);
        end
        prev_wren = (pm_wren === 1'b1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_nib(input logic [3:0] n, input int maxgap);
        int  g;
        int  w;
        bit  sent;
        g = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
        repeat (g) tick();
        nib_in    = n;
        nib_valid = 1'b1;
        w         = 0;
        sent      = 1'b0;
        while (!sent && w < 3000) begin
            if (nib_ready === 1'b1) sent = 1'b1;
            tick();
            w++;
        end
        if (!sent) begin
            tests++;
            fails++;
            $display("FAIL nib_accept_timeout: nibble %0h never accepted", n);
        end
        nib_valid = 1'b0;
        nib_in    = 4'($urandom);
    endtask

    task automatic send_byte(input logic [7:0] b, input int maxgap);
        send_nib(b[7:4], maxgap);
        send_nib(b[3:0], maxgap);
    endtask

    task automatic wait_idle(input int bound, output int cnt);
        cnt = 0;
        while (busy !== 1'b0 && cnt < bound) begin
            @(negedge clk);
            cnt++;
        end
        check("reach_idle", 32'(busy), 32'd0);
        tick();
    endtask

    // Full load of img[0..img_n-1]; expectations come from the stream rules only.
    task automatic load(input logic [7:0] csum, input int maxgap, input bit start_mid);
        logic [7:0] s;
        logic [7:0] a;
        int         cnt;
        bit         ok;
        s = 8'd0;
        for (int i = 0; i < img_n; i++) s = s + img[i];
        ok = (s == csum);
        pulse_start();
        check("hold_after_start", 32'(cpu_hold), 32'd1);
        check("done_clr_after_start", 32'(load_done), 32'd0);
        send_byte(8'(img_n), maxgap);
        for (int i = 0; i < img_n; i++) begin
            a = 8'(i);
            send_nib(img[i][7:4], maxgap);
            exp_q.push_back('{addr: a, data: img[i]});
            ref_mem[a] = img[i];
            send_nib(img[i][3:0], maxgap);
            if (start_mid && i == img_n / 2) pulse_start();
        end
        send_byte(csum, maxgap);
        wait_idle(50, cnt);
        check("load_done", 32'(load_done), ok ? 32'd1 : 32'd0);
        check("error_code", 32'(error_code), ok ? 32'd0 : 32'd1);
        check("cpu_hold", 32'(cpu_hold), ok ? 32'd0 : 32'd1);
        check("final_addr", 32'(pm_wr_addr), 32'(img_n % 256));
        check("queue_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int cnt;
        reset     = 1'b1;
        start     = 1'b0;
        nib_valid = 1'b0;
        nib_in    = 4'd0;
        for (int i = 0; i < 256; i++) begin
            obs_mem[i] = 8'd0;
            ref_mem[i] = 8'd0;
        end
        repeat (4) tick();
        check("rst_nib_ready", 32'(nib_ready), 32'd0);
        check("rst_addr", 32'(pm_wr_addr), 32'd0);
        check("rst_data", 32'(pm_wr_data), 32'd0);
        check("rst_wren", 32'(pm_wren), 32'd0);
        check("rst_hold", 32'(cpu_hold), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(load_done), 32'd0);
        check("rst_err", 32'(error_code), 32'd0);
        reset = 1'b0;
        repeat (2) tick();

        // Reference image, good checksum
        img[0] = 8'hA1; img[1] = 8'hB2; img[2] = 8'hC3; img_n = 3;
        load(8'h16, 0, 1'b0);
        // Same image, bad checksum
        load(8'h17, 0, 1'b0);

        // LEN=00 means a full 256-word image
        for (int i = 0; i < 256; i++) img[i] = 8'h01;
        img_n = 256;
        load(8'h00, 0, 1'b0);

        // Stall after LEN until timeout
        pulse_start();
        send_byte(8'h05, 0);
        cnt = 0;
        while (busy !== 1'b0 && cnt < 3000) begin
            @(negedge clk);
            cnt++;
        end
        check("timeout_cycles", 32'(cnt >= TIMEOUT - 2 && cnt <= TIMEOUT + 2), 32'd1);
        check("timeout_err", 32'(error_code), 32'd2);
        check("timeout_hold", 32'(cpu_hold), 32'd1);
        check("timeout_done", 32'(load_done), 32'd0);
        tick();
        img_n = 4;
        for (int i = 0; i < 4; i++) img[i] = 8'($urandom);
        img[4] = img[0] + img[1] + img[2] + img[3];
        load(img[4], 0, 1'b0);

        // Reset in the middle of the second data byte
        pulse_start();
        send_byte(8'h04, 0);
        send_nib(4'h5, 0);
        exp_q.push_back('{addr: 8'h00, data: 8'h5A});
        ref_mem[0] = 8'h5A;
        send_nib(4'hA, 0);
        send_nib(4'h6, 0);
        reset = 1'b1;
        check("rst_mid_wren", 32'(pm_wren), 32'd0);
        repeat (2) tick();
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_hold", 32'(cpu_hold), 32'd1);
        check("rst_mid_ready", 32'(nib_ready), 32'd0);
        check("rst_mid_wren2", 32'(pm_wren), 32'd0);
        reset = 1'b0;
        repeat (2) tick();
        check("rst_mid_queue", 32'(exp_q.size()), 32'd0);

        // Random images with gaps and an ignored start pulse mid-load
        for (int k = 0; k < 5; k++) begin
            logic [7:0] s;
            img_n = int'($urandom_range(20, 1));
            s = 8'd0;
            for (int i = 0; i < img_n; i++) begin
                img[i] = 8'($urandom);
                s = s + img[i];
            end
            load(s, 6, 1'b1);
        end
        tests++;
        begin
            int bad;
            bad = -1;
            for (int i = 0; i < 256; i++)
                if (bad < 0 && obs_mem[i] !== ref_mem[i]) bad = i;
            if (bad >= 0) begin
                fails++;
                $display("FAIL mem_image: addr %0h got %0h expected %0h", bad, obs_mem[bad], ref_mem[bad]);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1);
    end

endmodule
